// File: rtl/pipe_pkg.sv
// Shared definitions for the Y86-64 pipeline register bank: stage bus
// structs, their widths, encodings for stat/icode/register IDs and the
// bubble value that each stage register loads on a bubble or on reset.
package pipe_pkg;

  // Status codes; SBUB marks a slot that carries no instruction
  typedef enum logic [2:0] {
    SBUB = 3'd0,
    SAOK = 3'd1,
    SADR = 3'd2,
    SINS = 3'd3,
    SHLT = 3'd4
  } stat_e;

  // Instruction codes
  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    NOP     = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  localparam logic [3:0] RNONE    = 4'hF;
  localparam logic [2:0] CC_RESET = 3'b100;  // ZF=1, SF=0, OF=0

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } d_bus_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_bus_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } m_bus_t;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_bus_t;

  localparam int D_BUS_W = $bits(d_bus_t);
  localparam int E_BUS_W = $bits(e_bus_t);
  localparam int M_BUS_W = $bits(m_bus_t);
  localparam int W_BUS_W = $bits(w_bus_t);

  localparam d_bus_t D_BUBBLE = '{stat: SBUB, icode: NOP, ifun: 4'h0,
                                  rA: RNONE, rB: RNONE,
                                  valC: 64'h0, valP: 64'h0};

  localparam e_bus_t E_BUBBLE = '{stat: SBUB, icode: NOP, ifun: 4'h0,
                                  valC: 64'h0, valA: 64'h0, valB: 64'h0,
                                  dstE: RNONE, dstM: RNONE,
                                  srcA: RNONE, srcB: RNONE};

  localparam m_bus_t M_BUBBLE = '{stat: SBUB, icode: NOP, cnd: 1'b0,
                                  valE: 64'h0, valA: 64'h0,
                                  dstE: RNONE, dstM: RNONE};

  localparam w_bus_t W_BUBBLE = '{stat: SBUB, icode: NOP,
                                  valE: 64'h0, valM: 64'h0,
                                  dstE: RNONE, dstM: RNONE};

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: hold on stall, load the bubble value on
// bubble, otherwise load d. Stall has priority over bubble. Reset loads
// the bubble value asynchronously.
module pipe_stage_reg #(
  parameter int           W       = 8,
  parameter logic [W-1:0] BUB_VAL = {W{1'b0}}
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         stall_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_nxt;

  // Select next value: stall beats bubble, bubble beats a normal load
  always_comb begin
    w_nxt = d_i;
    if (stall_i) begin
      w_nxt = r_q;
    end else if (bubble_i) begin
      w_nxt = BUB_VAL;
    end else begin
      w_nxt = d_i;
    end
  end

  // Stage state; reset forces the bubble immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= BUB_VAL;
    end else begin
      r_q <= w_nxt;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/pipe_regs.sv
// Pipeline register bank of the five-stage Y86-64 core: predicted PC,
// D/E/M/W stage registers and the condition-code register, driven by the
// hazard unit's stall/bubble/set-cc controls.
// Optional macro PIPE_PERF_CNT_EN builds the saturating cycle/stall/bubble
// performance counters; without it the counter outputs are tied to zero.
module pipe_regs
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               F_stall_i,
  input  logic               D_stall_i,
  input  logic               D_bubble_i,
  input  logic               E_bubble_i,
  input  logic               M_bubble_i,
  input  logic               W_stall_i,
  input  logic               set_cc_i,
  input  logic [63:0]        f_pred_pc_i,
  input  logic [D_BUS_W-1:0] f_bus_i,
  input  logic [E_BUS_W-1:0] d_bus_i,
  input  logic [M_BUS_W-1:0] e_bus_i,
  input  logic [W_BUS_W-1:0] m_bus_i,
  input  logic [2:0]         e_cc_i,
  output logic [63:0]        F_pred_pc_o,
  output logic [D_BUS_W-1:0] D_bus_o,
  output logic [E_BUS_W-1:0] E_bus_o,
  output logic [M_BUS_W-1:0] M_bus_o,
  output logic [W_BUS_W-1:0] W_bus_o,
  output logic [2:0]         cc_o,
  output logic [CNT_W-1:0]   cyc_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o
);

  logic [63:0] r_pred_pc;
  logic [2:0]  r_cc;

  // D: both stall and bubble are possible
  pipe_stage_reg #(.W(D_BUS_W), .BUB_VAL(D_BUBBLE)) u_d_reg (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_i(D_stall_i), .bubble_i(D_bubble_i),
    .d_i(f_bus_i), .q_o(D_bus_o)
  );

  // E: bubble only
  pipe_stage_reg #(.W(E_BUS_W), .BUB_VAL(E_BUBBLE)) u_e_reg (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_i(1'b0), .bubble_i(E_bubble_i),
    .d_i(d_bus_i), .q_o(E_bus_o)
  );

  // M: bubble only
  pipe_stage_reg #(.W(M_BUS_W), .BUB_VAL(M_BUBBLE)) u_m_reg (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_i(1'b0), .bubble_i(M_bubble_i),
    .d_i(e_bus_i), .q_o(M_bus_o)
  );

  // W: stall only
  pipe_stage_reg #(.W(W_BUS_W), .BUB_VAL(W_BUBBLE)) u_w_reg (
    .clk_i(clk_i), .rst_i(rst_i),
    .stall_i(W_stall_i), .bubble_i(1'b0),
    .d_i(m_bus_i), .q_o(W_bus_o)
  );

  // Predicted PC: hold while fetch is stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pred_pc <= 64'h0;
    end else if (F_stall_i) begin
      r_pred_pc <= r_pred_pc;
    end else begin
      r_pred_pc <= f_pred_pc_i;
    end
  end

  // Condition codes: independent of every stage control
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cc <= CC_RESET;
    end else if (set_cc_i) begin
      r_cc <= e_cc_i;
    end else begin
      r_cc <= r_cc;
    end
  end

  assign F_pred_pc_o = r_pred_pc;
  assign cc_o        = r_cc;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_any_stall;
  logic             w_any_bubble;

  assign w_any_stall  = F_stall_i | D_stall_i | W_stall_i;
  assign w_any_bubble = D_bubble_i | E_bubble_i | M_bubble_i;

  // Saturating counters, sampled on the same edge as the stage registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cyc_cnt    <= {CNT_W{1'b0}};
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_cyc_cnt != CNT_MAX) begin
        r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
      end else begin
        r_cyc_cnt <= r_cyc_cnt;
      end
      if (w_any_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (w_any_bubble && (r_bubble_cnt != CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      end else begin
        r_bubble_cnt <= r_bubble_cnt;
      end
    end
  end

  assign cyc_cnt_o    = r_cyc_cnt;
  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`else
  assign cyc_cnt_o    = {CNT_W{1'b0}};
  assign stall_cnt_o  = {CNT_W{1'b0}};
  assign bubble_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_regs.sv
// Self-checking bench for pipe_regs: reset checks, a loop-back pipeline
// flow, a table of hazard-control patterns, randomized traffic against a
// rule-level model, and counter window/saturation checks.
module tb_pipe_regs;
  import pipe_pkg::*;

  localparam int TB_CNT_W = 8;
  localparam int CNT_MAX  = 255;

  logic clk = 1'b0;
  logic rst;
  logic fs, ds, db, eb, mb, ws, scc;
  logic [2:0]  ecc;
  logic [63:0] f_pc;
  logic        loop_en;
  d_bus_t f_bus;
  e_bus_t d_bus, d_bus_rnd, d_bus_loop;
  m_bus_t e_bus, e_bus_rnd, e_bus_loop;
  w_bus_t m_bus, m_bus_rnd, m_bus_loop;

  logic [63:0] pc_o;
  d_bus_t D_o;
  e_bus_t E_o;
  m_bus_t M_o;
  w_bus_t W_o;
  logic [2:0] cc_o;
  logic [TB_CNT_W-1:0] cyc_o, stall_o, bub_o;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  d_bus_t m_d;
  e_bus_t m_e;
  m_bus_t m_m;
  w_bus_t m_w;
  logic [63:0] m_pc;
  logic [2:0]  m_cc;
  int m_cyc, m_stall, m_bub;

  typedef struct {
    logic [6:0] ctl;   // {fs, ds, db, eb, mb, ws, scc}
    logic [2:0] ecc;
    int d_k, e_k, m_k, w_k, pc_k, cc_k;  // 0 load, 1 hold, 2 bubble
  } vec_t;
  vec_t tbl [13];

  pipe_regs #(.CNT_W(TB_CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .F_stall_i(fs), .D_stall_i(ds), .D_bubble_i(db),
    .E_bubble_i(eb), .M_bubble_i(mb), .W_stall_i(ws), .set_cc_i(scc),
    .f_pred_pc_i(f_pc), .f_bus_i(f_bus), .d_bus_i(d_bus),
    .e_bus_i(e_bus), .m_bus_i(m_bus), .e_cc_i(ecc),
    .F_pred_pc_o(pc_o), .D_bus_o(D_o), .E_bus_o(E_o),
    .M_bus_o(M_o), .W_bus_o(W_o), .cc_o(cc_o),
    .cyc_cnt_o(cyc_o), .stall_cnt_o(stall_o), .bubble_cnt_o(bub_o)
  );

  always #5 clk = ~clk;

  // simple stage logic for the loop-back flow (irmovq: valE = valC)
  always_comb begin
    d_bus_loop       = '0;
    d_bus_loop.stat  = D_o.stat;
    d_bus_loop.icode = D_o.icode;
    d_bus_loop.ifun  = D_o.ifun;
    d_bus_loop.valC  = D_o.valC;
    d_bus_loop.dstE  = D_o.rB;
    d_bus_loop.dstM  = 4'hF;
    d_bus_loop.srcA  = 4'hF;
    d_bus_loop.srcB  = 4'hF;
    e_bus_loop       = '0;
    e_bus_loop.stat  = E_o.stat;
    e_bus_loop.icode = E_o.icode;
    e_bus_loop.valE  = E_o.valC;
    e_bus_loop.dstE  = E_o.dstE;
    e_bus_loop.dstM  = E_o.dstM;
    m_bus_loop       = '0;
    m_bus_loop.stat  = M_o.stat;
    m_bus_loop.icode = M_o.icode;
    m_bus_loop.valE  = M_o.valE;
    m_bus_loop.dstE  = M_o.dstE;
    m_bus_loop.dstM  = M_o.dstM;
  end

  assign d_bus = loop_en ? d_bus_loop : d_bus_rnd;
  assign e_bus = loop_en ? e_bus_loop : e_bus_rnd;
  assign m_bus = loop_en ? m_bus_loop : m_bus_rnd;

  function automatic d_bus_t bub_d();
    d_bus_t b;
    b.stat = 3'd0; b.icode = 4'h1; b.ifun = 4'h0;
    b.rA = 4'hF; b.rB = 4'hF; b.valC = 64'd0; b.valP = 64'd0;
    return b;
  endfunction

  function automatic e_bus_t bub_e();
    e_bus_t b;
    b.stat = 3'd0; b.icode = 4'h1; b.ifun = 4'h0;
    b.valC = 64'd0; b.valA = 64'd0; b.valB = 64'd0;
    b.dstE = 4'hF; b.dstM = 4'hF; b.srcA = 4'hF; b.srcB = 4'hF;
    return b;
  endfunction

  function automatic m_bus_t bub_m();
    m_bus_t b;
    b.stat = 3'd0; b.icode = 4'h1; b.cnd = 1'b0;
    b.valE = 64'd0; b.valA = 64'd0; b.dstE = 4'hF; b.dstM = 4'hF;
    return b;
  endfunction

  function automatic w_bus_t bub_w();
    w_bus_t b;
    b.stat = 3'd0; b.icode = 4'h1;
    b.valE = 64'd0; b.valM = 64'd0; b.dstE = 4'hF; b.dstM = 4'hF;
    return b;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic int cexp(input int v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " D_bus"}, 256'(D_o), 256'(m_d));
    chk({tag, " E_bus"}, 256'(E_o), 256'(m_e));
    chk({tag, " M_bus"}, 256'(M_o), 256'(m_m));
    chk({tag, " W_bus"}, 256'(W_o), 256'(m_w));
    chk({tag, " pred_pc"}, 256'(pc_o), 256'(m_pc));
    chk({tag, " cc"}, 256'(cc_o), 256'(m_cc));
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, " cyc_cnt"}, 256'(cyc_o), 256'(cexp(m_cyc)));
    chk({tag, " stall_cnt"}, 256'(stall_o), 256'(cexp(m_stall)));
    chk({tag, " bubble_cnt"}, 256'(bub_o), 256'(cexp(m_bub)));
  endtask

  task automatic model_reset();
    m_d = bub_d(); m_e = bub_e(); m_m = bub_m(); m_w = bub_w();
    m_pc = 64'd0; m_cc = 3'b100;
    m_cyc = 0; m_stall = 0; m_bub = 0;
  endtask

  task automatic rand_inputs();
    logic [255:0] t;
    f_pc = r64();
    t = {r64(), r64(), r64(), r64()}; f_bus     = t[D_BUS_W-1:0];
    t = {r64(), r64(), r64(), r64()}; d_bus_rnd = t[E_BUS_W-1:0];
    t = {r64(), r64(), r64(), r64()}; e_bus_rnd = t[M_BUS_W-1:0];
    t = {r64(), r64(), r64(), r64()}; m_bus_rnd = t[W_BUS_W-1:0];
  endtask

  task automatic ctl_zero();
    {fs, ds, db, eb, mb, ws, scc} = 7'd0;
  endtask

  // one rising edge; counter model advances on every edge outside reset
  task automatic tick();
    logic was_rst, any_s, any_b;
    was_rst = rst;
    any_s   = fs | ds | ws;
    any_b   = db | eb | mb;
    @(posedge clk);
    #1;
    if (!was_rst) begin
      m_cyc = (m_cyc < CNT_MAX) ? m_cyc + 1 : m_cyc;
      if (any_s) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
      if (any_b) m_bub = (m_bub < CNT_MAX) ? m_bub + 1 : m_bub;
    end
  endtask

  // async reset without any clock edge, check, then release after an edge
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    check_cnt(tag);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; loop_en = 1'b0; ecc = 3'd0;
    ctl_zero();
    rand_inputs();
    #3;
    model_reset();
    check_all("reset0");
    check_cnt("reset0");
    tick();
    rst = 1'b0;

    // ---- loop-back flow: irmovq $0x10 walks D -> E -> M -> W ----
    loop_en = 1'b1;
    f_bus = '0;
    f_bus.stat = 3'd1; f_bus.icode = 4'h3; f_bus.rA = 4'hF; f_bus.rB = 4'h2;
    f_bus.valC = 64'h10; f_bus.valP = 64'ha;
    tick();
    chk("flow D icode", 256'(D_o.icode), 256'(4'h3));
    chk("flow D valC", 256'(D_o.valC), 256'(64'h10));
    f_bus = '0;
    f_bus.stat = 3'd1; f_bus.icode = 4'h1; f_bus.rA = 4'hF; f_bus.rB = 4'hF;
    tick();
    chk("flow E icode", 256'(E_o.icode), 256'(4'h3));
    chk("flow E valC", 256'(E_o.valC), 256'(64'h10));
    chk("flow D next", 256'(D_o.icode), 256'(4'h1));
    tick();
    chk("flow M valE", 256'(M_o.valE), 256'(64'h10));
    tick();
    chk("flow W valE", 256'(W_o.valE), 256'(64'h10));
    chk("flow W dstE", 256'(W_o.dstE), 256'(4'h2));
    loop_en = 1'b0;

    do_reset("reset1");

    // ---- table of hazard-control patterns ----
    tbl[0]  = '{7'b0000000, 3'b000, 0, 0, 0, 0, 0, 1};  // normal, ADDQ into D
    tbl[1]  = '{7'b1101000, 3'b000, 1, 2, 0, 0, 1, 1};  // load-use stall
    tbl[2]  = '{7'b0000000, 3'b000, 0, 0, 0, 0, 0, 1};  // resume
    tbl[3]  = '{7'b0110000, 3'b000, 1, 0, 0, 0, 0, 1};  // D stall beats bubble
    tbl[4]  = '{7'b0010000, 3'b000, 2, 0, 0, 0, 0, 1};  // D bubble
    tbl[5]  = '{7'b0000100, 3'b000, 0, 0, 2, 0, 0, 1};  // M bubble
    tbl[6]  = '{7'b0000001, 3'b010, 0, 0, 0, 0, 0, 0};  // set cc = 010
    for (int k = 7; k < 12; k++) begin
      tbl[k] = '{7'b0000010, 3'b111, 0, 0, 0, 1, 0, 1}; // W stall, cc frozen
    end
    tbl[12] = '{7'b1111111, 3'b001, 1, 2, 2, 1, 1, 0};  // everything at once

    for (int i = 0; i < 13; i++) begin
      rand_inputs();
      {fs, ds, db, eb, mb, ws, scc} = tbl[i].ctl;
      ecc = tbl[i].ecc;
      if (i == 0) begin
        f_bus.icode = 4'h6;
        f_bus.ifun  = 4'h0;
      end
      tick();
      case (tbl[i].d_k)
        0: m_d = f_bus;
        1: m_d = m_d;
        default: m_d = bub_d();
      endcase
      m_e  = (tbl[i].e_k == 2) ? bub_e() : d_bus_rnd;
      m_m  = (tbl[i].m_k == 2) ? bub_m() : e_bus_rnd;
      m_w  = (tbl[i].w_k == 1) ? m_w : m_bus_rnd;
      m_pc = (tbl[i].pc_k == 1) ? m_pc : f_pc;
      m_cc = (tbl[i].cc_k == 1) ? m_cc : ecc;
      check_all($sformatf("row%0d", i));
    end
    check_cnt("table");

    // ---- randomized traffic against the rule model ----
    for (int n = 0; n < 200; n++) begin
      rand_inputs();
      fs  = ($urandom_range(3) == 0);
      ds  = ($urandom_range(3) == 0);
      db  = ($urandom_range(3) == 0);
      eb  = ($urandom_range(3) == 0);
      mb  = ($urandom_range(3) == 0);
      ws  = ($urandom_range(3) == 0);
      scc = ($urandom_range(1) == 0);
      ecc = 3'($urandom_range(7));
      tick();
      if (!ds) m_d = db ? bub_d() : f_bus;
      m_e = eb ? bub_e() : d_bus_rnd;
      m_m = mb ? bub_m() : e_bus_rnd;
      if (!ws) m_w = m_bus_rnd;
      if (!fs) m_pc = f_pc;
      if (scc) m_cc = ecc;
      check_all($sformatf("rnd%0d", n));
      check_cnt($sformatf("rnd%0d", n));
    end

    // ---- reset in the middle of a stall, buses full of data ----
    fs = 1'b1; ds = 1'b1; ws = 1'b1;
    do_reset("reset_midstall");
    chk("reset icode", 256'(E_o.icode), 256'(4'h1));
    chk("reset dstE", 256'(M_o.dstE), 256'(4'hF));
    ctl_zero();

    // ---- counter window: 10 cycles, 3 with stall, 2 with bubble ----
    do_reset("reset_cnt");
    for (int c = 0; c < 10; c++) begin
      ctl_zero();
      ds = (c >= 1 && c <= 3);
      eb = (c == 5 || c == 7);
      tick();
    end
    ctl_zero();
    chk("window cyc_cnt", 256'(cyc_o), 256'(cexp(10)));
    chk("window stall_cnt", 256'(stall_o), 256'(cexp(3)));
    chk("window bubble_cnt", 256'(bub_o), 256'(cexp(2)));

    // ---- saturation: run past 2^8-1 cycles with a constant stall ----
    fs = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    fs = 1'b0;
    chk("sat cyc_cnt", 256'(cyc_o), 256'(cexp(255)));
    chk("sat stall_cnt", 256'(stall_o), 256'(cexp(255)));
    chk("sat bubble_cnt", 256'(bub_o), 256'(cexp(2)));
    check_cnt("sat model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_regs.md
# pipe_regs

Pipeline register bank for the five-stage Y86-64 core. It holds the predicted PC and the D, E, M and W stage registers, plus the condition-code register. It consumes the stall, bubble and set-cc signals produced by the hazard control unit and applies them each cycle: a stalled register holds its value, and a bubbled register loads a NOP bubble. It sits between the combinational stage logic (fetch, decode, execute, memory) and the register outputs that feed the next stage.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (used only under PIPE_PERF_CNT_EN)

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- F_stall_i  in  1  hold the predicted PC
- D_stall_i  in  1  hold the D register
- D_bubble_i  in  1  load a bubble into D
- E_bubble_i  in  1  load a bubble into E
- M_bubble_i  in  1  load a bubble into M
- W_stall_i  in  1  hold the W register
- set_cc_i  in  1  load the CC register from e_cc_i
- f_pred_pc_i  in  64  next predicted PC from fetch
- f_bus_i  in  D_BUS_W  fetch outputs: stat, icode, ifun, rA, rB, valC, valP
- d_bus_i  in  E_BUS_W  decode outputs: stat, icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB
- e_bus_i  in  M_BUS_W  execute outputs: stat, icode, Cnd, valE, valA, dstE, dstM
- m_bus_i  in  W_BUS_W  memory outputs: stat, icode, valE, valM, dstE, dstM
- e_cc_i  in  3  {ZF, SF, OF} computed by the ALU
- F_pred_pc_o  out  64  registered predicted PC
- D_bus_o  out  D_BUS_W  registered D stage
- E_bus_o  out  E_BUS_W  registered E stage
- M_bus_o  out  M_BUS_W  registered M stage
- W_bus_o  out  W_BUS_W  registered W stage
- cc_o  out  3  registered {ZF, SF, OF}
- cyc_cnt_o  out  CNT_W  cycles since reset
- stall_cnt_o  out  CNT_W  cycles in which any stall input was high
- bubble_cnt_o  out  CNT_W  cycles in which any bubble input was high

## Operation
- **Bubble value for every stage bus:**
  - stat = `SBUB`, icode = `NOP`, ifun = 0.
  - All register-ID fields (rA, rB, srcA, srcB, dstE, dstM) = `RNONE` (4'hF).
  - Cnd = 0; all 64-bit data fields = 0.
- **Per-edge rule for D:**
  - D_stall_i high: hold.
  - Else D_bubble_i high: load the bubble.
  - Else: load f_bus_i.
- **Precedence:** if stall and bubble are both high for the same register, stall wins. The bench checks this explicitly.
- **E:** E_bubble_i high loads the bubble; otherwise load d_bus_i. E has no stall.
- **M:** M_bubble_i high loads the bubble; otherwise load e_bus_i.
- **W:** W_stall_i high holds; otherwise load m_bus_i. W has no bubble.
- **Predicted PC:** F_stall_i high holds; otherwise load f_pred_pc_i.
- **CC register:** set_cc_i high loads e_cc_i; otherwise hold. CC is independent of all stage controls.
- **Reset values:**
  - All four stage buses = bubble value.
  - F_pred_pc_o = 0.
  - cc_o = 3'b100 (ZF=1).
  - All counters = 0.
- **Counters:**
  - Each counter increments by 1 per cycle while its condition holds.
  - Counters saturate at all-ones; they never wrap.

## Timing
- Every output is a direct flop output with one-cycle latency from its input; there are no combinational input-to-output paths.
- Stall and bubble inputs are sampled on the same edge as the data they qualify.
- A held register keeps its exact value for as many consecutive cycles as the stall stays high.
- Asserting rst_i at any time, including mid-stall, forces the reset values immediately, without waiting for a clock edge.
- Deasserting rst_i takes effect at the first rising edge after release.
- Counters update on the same edge as the stage registers. The counter for a given cycle reflects the controls sampled on that edge.

## Configuration
- Macro: `PIPE_PERF_CNT_EN`.
- **Defined:** cyc_cnt_o, stall_cnt_o and bubble_cnt_o are implemented as described above.
- **Undefined:** the counter flops are not built, and the three counter outputs are tied to 0. Ports are unchanged.

## Structure
- **Shared package `pipe_pkg`:**
  - Packed stage structs `d_bus_t`, `e_bus_t`, `m_bus_t`, `w_bus_t`, and their widths D_BUS_W..W_BUS_W.
  - A bubble constant for each struct.
  - `RNONE`.
  - `NOP`, `SBUB` and the stat codes, with values from define.v.
- **Sub-module:** one natural sub-module, `pipe_stage_reg`.
  - Parameterized by width and bubble value, with ports stall, bubble, d, q.
  - Instantiated four times: W ties bubble low, E and M tie stall low.

## Test plan
- Reset: pulse rst_i mid-run with all buses carrying data -> immediately all buses show icode=`NOP`, stat=`SBUB`, dstE=4'hF; F_pred_pc_o=0; cc_o=3'b100.
- Normal flow: f_bus_i icode=`IRMOVQ`, valC=64'h10 -> appears on D_bus_o after 1 edge, E after 2, M after 3, W after 4.
- Load-use stall: F_stall_i=D_stall_i=E_bubble_i=1 for one cycle, with D holding `ADDQ` -> F_pred_pc_o and D_bus_o unchanged, E_bus_o becomes the bubble; the next cycle resumes.
- Stall vs bubble on D: D_stall_i=D_bubble_i=1 -> D_bus_o holds its prior value; no bubble is loaded.
- CC and exception: set_cc_i=1 with e_cc_i=3'b010 -> cc_o=3'b010; then set_cc_i=0 and W_stall_i=1 for 5 cycles -> cc_o and W_bus_o both frozen.
- Counters (macro defined): 3 stall cycles and 2 bubble cycles in a 10-cycle window -> cyc=10, stall=3, bubble=2. Forcing a counter near all-ones -> it saturates rather than wrapping.
